// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for the two-requester shift-register arbiter.
package shift_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_WAIT = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    localparam int TIMEOUT_EXTRA_DEFAULT = 4;

    // Width able to hold values 0..limit inclusive.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/shift_arbiter_rr_select2.sv
// Two-way round-robin selector: the requester that did not win last time
// takes priority when both are asking.
module rr_select2 (
    input  logic [1:0] req,
    input  logic       lastGrant,
    output logic       winner,
    output logic       valid
);

    // Pick the winner purely from the current request pattern and history.
    always_comb begin
        valid  = |req;
        winner = 1'b0;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~lastGrant;
            default: winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// Arbitrates two word sources onto one external shift register, sequencing
// load, completion wait with timeout, and sticky error reporting.
//
//   state | meaning
//   IDLE  | no transfer; sample req and grant a winner
//   LOAD  | one-cycle load strobe to the shift register
//   WAIT  | waiting for shiftComplete, timeout counter running
//   DONE  | one-cycle completion pulse
//   ERR   | one-cycle timeout state, sets sticky errFlag
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int bitLength    = 16,
    parameter int timeoutExtra = TIMEOUT_EXTRA_DEFAULT
) (
    input  logic                 shiftClk,
    input  logic                 reset,
    input  logic [1:0]           req,
    input  logic [bitLength-1:0] dataIn0,
    input  logic [bitLength-1:0] dataIn1,
    input  logic                 shiftComplete,
    output logic [1:0]           ack,
    output logic                 loadData,
    output logic [bitLength-1:0] dataBus,
    output logic                 busy,
    output logic                 activeSrc,
    output logic                 donePulse,
    output logic                 errFlag
);

    localparam int LIMIT = bitLength + timeoutExtra;
    localparam int CNT_W = cnt_width(LIMIT);
    // Leaving WAIT from this count puts ERR exactly LIMIT cycles after LOAD.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LIMIT - 2);

    state_t               state, state_next;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 last_q, last_d;
    logic [1:0]           ack_q, ack_d;
    logic                 load_q, load_d;
    logic [bitLength-1:0] data_q, data_d;
    logic                 busy_q, busy_d;
    logic                 src_q, src_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 winner;
    logic                 grant_valid;

    rr_select2 u_rr_select2 (
        .req       (req),
        .lastGrant (last_q),
        .winner    (winner),
        .valid     (grant_valid)
    );

    // Next-state and next-output decode; outputs are registered below.
    always_comb begin
        state_next = state;
        cnt_d      = cnt_q;
        last_d     = last_q;
        ack_d      = 2'b00;
        load_d     = 1'b0;
        data_d     = data_q;
        src_d      = src_q;
        done_d     = 1'b0;
        err_d      = err_q;
        case (state)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_next = ST_LOAD;
                    ack_d      = winner ? 2'b10 : 2'b01;
                    data_d     = winner ? dataIn1 : dataIn0;
                    src_d      = winner;
                    last_d     = winner;
                    load_d     = 1'b1;
                end
            end
            ST_LOAD: begin
                state_next = ST_WAIT;
                cnt_d      = '0;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // The first WAIT cycle may still see a stale completion flag.
                if ((cnt_q != '0) && shiftComplete) begin
                    state_next = ST_DONE;
                    done_d     = 1'b1;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_next = ST_ERR;
                    err_d      = 1'b1;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            ST_ERR:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        busy_d = (state_next != ST_IDLE);
    end

    // State and registered outputs; reset overrides any transfer in flight.
    always_ff @(posedge shiftClk) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt_q  <= '0;
            last_q <= 1'b1;
            ack_q  <= 2'b00;
            load_q <= 1'b0;
            data_q <= '0;
            busy_q <= 1'b0;
            src_q  <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_next;
            cnt_q  <= cnt_d;
            last_q <= last_d;
            ack_q  <= ack_d;
            load_q <= load_d;
            data_q <= data_d;
            busy_q <= busy_d;
            src_q  <= src_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    assign ack       = ack_q;
    assign loadData  = load_q;
    assign dataBus   = data_q;
    assign busy      = busy_q;
    assign activeSrc = src_q;
    assign donePulse = done_q;
    assign errFlag   = err_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter with a behavioural 16-bit shift register attached.
module tb_shift_arbiter;

    localparam int BITS = 16;

    logic              shift_clk = 1'b0;
    logic              reset = 1'b1;
    logic [1:0]        req = 2'b00;
    logic [BITS-1:0]   data_in0 = '0;
    logic [BITS-1:0]   data_in1 = '0;
    logic              shift_complete;
    logic [1:0]        ack;
    logic              load_data;
    logic [BITS-1:0]   data_bus;
    logic              busy;
    logic              active_src;
    logic              done_pulse;
    logic              err_flag;
    logic              stall = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic m_last = 1'b1;
    logic m_err  = 1'b0;

    always #5 shift_clk = ~shift_clk;

    shift_arbiter #(.bitLength(BITS), .timeoutExtra(4)) dut (
        .shiftClk      (shift_clk),
        .reset         (reset),
        .req           (req),
        .dataIn0       (data_in0),
        .dataIn1       (data_in1),
        .shiftComplete (shift_complete),
        .ack           (ack),
        .loadData      (load_data),
        .dataBus       (data_bus),
        .busy          (busy),
        .activeSrc     (active_src),
        .donePulse     (done_pulse),
        .errFlag       (err_flag)
    );

    // Downstream shift register, active-low reset tied to the same source.
    logic            sr_rst_b;
    logic [BITS-1:0] sr;
    logic [BITS-1:0] stream;
    int              bits_left;
    logic            sr_done;

    assign sr_rst_b = ~reset;

    always @(posedge shift_clk or negedge sr_rst_b) begin
        if (!sr_rst_b) begin
            sr        <= '0;
            stream    <= '0;
            bits_left <= 0;
            sr_done   <= 1'b0;
        end else if (load_data) begin
            sr        <= data_bus;
            stream    <= '0;
            bits_left <= BITS;
            sr_done   <= 1'b0;
        end else if (bits_left > 0) begin
            sr        <= sr >> 1;
            stream    <= {sr[0], stream[BITS-1:1]};
            bits_left <= bits_left - 1;
            sr_done   <= (bits_left == 1);
        end else begin
            sr_done   <= 1'b0;
        end
    end

    assign shift_complete = sr_done & ~stall;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge shift_clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, " ack"}, ack, 0);
        check_val({tag, " loadData"}, load_data, 0);
        check_val({tag, " dataBus"}, data_bus, 0);
        check_val({tag, " busy"}, busy, 0);
        check_val({tag, " activeSrc"}, active_src, 0);
        check_val({tag, " donePulse"}, done_pulse, 0);
        check_val({tag, " errFlag"}, err_flag, 0);
    endtask

    // Wait for the LOAD cycle of a new grant; returns 1 if seen in budget.
    task automatic wait_load(output bit seen);
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick;
            if (load_data) seen = 1;
        end
    endtask

    // One complete transfer against the model. Normal transfers: DONE 18
    // cycles after LOAD (16 shifts plus completion latency), IDLE at 19.
    // Stalled transfers: ERR 20 cycles after LOAD, IDLE at 21.
    task automatic do_xfer(input logic [1:0] r, input logic [BITS-1:0] d0,
                           input logic [BITS-1:0] d1, input bit stall_it,
                           input bit hold, input string tag);
        logic            w;
        logic [BITS-1:0] word;
        bit              seen;
        int              k;
        int              idle_at;
        int              dones;
        w      = (r == 2'b11) ? ~m_last : (r == 2'b10);
        word   = w ? d1 : d0;
        m_last = w;
        req      = r;
        data_in0 = d0;
        data_in1 = d1;
        stall    = stall_it;
        wait_load(seen);
        check_val({tag, " load seen"}, seen, 1);
        if (!seen) return;
        check_val({tag, " ack"}, ack, w ? 2 : 1);
        check_val({tag, " dataBus"}, data_bus, word);
        check_val({tag, " activeSrc"}, active_src, w);
        check_val({tag, " busy"}, busy, 1);
        if (!hold) req = 2'b00;
        data_in0 = ~d0;
        data_in1 = ~d1;
        idle_at = 0;
        dones   = 0;
        k       = 0;
        while (k < 30 && idle_at == 0) begin
            tick;
            k++;
            if (k == 1) check_val({tag, " load one cycle"}, load_data, 0);
            if (k == 10) check_val({tag, " dataBus held"}, data_bus, word);
            if (done_pulse) begin
                dones++;
                check_val({tag, " done cycle"}, k, 18);
                check_val({tag, " dataBus at done"}, data_bus, word);
            end
            if (stall_it && k == 20) check_val({tag, " errFlag in ERR"}, err_flag, 1);
            if (!busy) idle_at = k;
        end
        check_val({tag, " idle cycle"}, idle_at, stall_it ? 21 : 19);
        check_val({tag, " done count"}, dones, stall_it ? 0 : 1);
        if (stall_it) m_err = 1'b1;
        check_val({tag, " errFlag"}, err_flag, m_err);
        if (!stall_it) check_val({tag, " serial"}, stream, word);
        stall = 1'b0;
    endtask

    initial begin
        bit seen;
        repeat (3) tick;
        check_reset_outputs("por");
        reset = 1'b0;
        repeat (2) tick;
        check_val("idle no req busy", busy, 0);
        check_val("idle no req ack", ack, 0);

        // round-robin contention from reset: grants 0, 1, 0
        do_xfer(2'b11, 16'h1111, 16'h2222, 0, 1, "cont0");
        do_xfer(2'b11, 16'h3333, 16'h4444, 0, 1, "cont1");
        do_xfer(2'b11, 16'h5555, 16'h6666, 0, 0, "cont2");

        do_xfer(2'b01, 16'hA5C3, 16'h0000, 0, 0, "single");

        do_xfer(2'b10, 16'h0F0F, 16'hBEEF, 1, 0, "timeout");
        do_xfer(2'b01, 16'h1234, 16'h5678, 0, 0, "after_err");

        // reset during WAIT cycle 5
        req      = 2'b01;
        data_in0 = 16'hCAFE;
        wait_load(seen);
        check_val("rst_mid load seen", seen, 1);
        req = 2'b00;
        repeat (5) tick;
        reset = 1'b1;
        tick;
        check_reset_outputs("rst_mid");
        reset  = 1'b0;
        m_last = 1'b1;
        m_err  = 1'b0;
        do_xfer(2'b11, 16'h7777, 16'h8888, 0, 0, "post_rst");

        for (int i = 0; i < 12; i++) begin
            logic [1:0] r;
            r = 2'($urandom_range(1, 3));
            do_xfer(r, 16'($urandom), 16'($urandom), ($urandom_range(0, 4) == 0), 0, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameter bitLength, default 16, word width of the downstream shift register and of each data port.
REQ-002 Parameter timeoutExtra, default 4, cycles of slack beyond bitLength before a transfer is declared hung.
REQ-003 shiftClk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of shiftClk.
REQ-005 req  input  2  per-requester request level; bit i held high while requester i has a word pending.
REQ-006 dataIn0, dataIn1  input  bitLength  word offered by requester 0 and requester 1.
REQ-007 shiftComplete  input  1  completion flag returned by the downstream shift register.
REQ-008 ack  output  2  one-cycle pulse on bit i when requester i's word is captured.
REQ-009 loadData  output  1  active-high load strobe to the shift register.
REQ-010 dataBus  output  bitLength  word presented to the shift register.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 activeSrc  output  1  index of the requester owning the current transfer.
REQ-013 donePulse  output  1  one-cycle pulse when a transfer completes normally.
REQ-014 errFlag  output  1  sticky timeout indicator.

Function
REQ-015 FSM states: IDLE, LOAD, WAIT, DONE, ERR. All outputs are registered (Moore).
REQ-016 IDLE: if any req bit is high, select a winner, latch its word into dataBus and its index into activeSrc, pulse ack for the winner, then go to LOAD. Otherwise stay in IDLE.
REQ-017 Arbitration is round-robin over lastGrant. With both req bits high, the requester not equal to lastGrant wins. With one req bit high, that requester wins. lastGrant updates at every grant.
REQ-018 LOAD lasts exactly one cycle with loadData=1; dataBus is held stable from LOAD through DONE. The next state is WAIT.
REQ-019 WAIT: the timeout counter clears on entry and increments each cycle. shiftComplete is ignored in the first WAIT cycle. After that, shiftComplete=1 moves to DONE. If the counter reaches bitLength+timeoutExtra first, the next state is ERR.
REQ-020 DONE lasts one cycle with donePulse=1, then returns to IDLE. A new grant takes at least one IDLE cycle, so back-to-back transfers are spaced 3 cycles plus the shift time.
REQ-021 ERR lasts one cycle. It sets errFlag=1, which stays high until reset, then returns to IDLE. No donePulse is issued for the failed transfer.
REQ-022 Requester changes to req or dataIn outside IDLE are ignored; a request that drops before IDLE samples it is not served.
REQ-023 The timeout counter width is ceil(log2(bitLength+timeoutExtra+1)) bits and never wraps, because it is cleared on WAIT entry.

Reset
REQ-024 Reset wins over all other conditions, including mid-transfer: next state IDLE and outputs ack=0, loadData=0, dataBus=0, busy=0, activeSrc=0, donePulse=0, errFlag=0.
REQ-025 Reset sets lastGrant=1, so requester 0 wins the first contention; the timeout counter resets to 0.
REQ-026 Reset does not drive the shift register's own reset. The system ties both resets from one source, inverted for the shift register's active-low reset.

Structure
REQ-027 The FSM state encoding and the default timeoutExtra value belong in a shared package.
REQ-028 The round-robin selection is a natural sub-module, rr_select2: inputs req and lastGrant, output winner index plus valid, purely combinational.
REQ-029 The shift register is instantiated by the parent; shift_arbiter contains no datapath shifting.

Verification
REQ-030 Bench instantiates shift_arbiter with a 16-bit shift register, both reset from one source.
REQ-031 Single request: req=01, dataIn0=16'hA5C3 -> ack=01 pulse, one loadData cycle with dataBus=16'hA5C3, donePulse within 20 cycles, serial LSB stream matches 16'hA5C3.
REQ-032 Contention: req=11 held high for three transfers -> grants in order 0, 1, 0, with activeSrc matching each grant.
REQ-033 Timeout: shiftComplete forced to 0 -> ERR reached 20 cycles after LOAD, errFlag=1 held, no donePulse, next request still served.
REQ-034 Reset mid-WAIT: assert reset for one cycle at WAIT cycle 5 -> all outputs take reset values the next cycle, and lastGrant=1 so requester 0 wins a subsequent 11 request.
REQ-035 Late data: dataIn0 changed during WAIT -> dataBus unchanged until DONE.
